// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer: FSM state encoding,
// the maximum countdown value and active-low seven-segment patterns (gfedcba).
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] REMAIN_MAX = 3'd4;

  // Active-low, bit order gfedcba: a lit segment is a 0.
  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Seconds still to go, given elapsed seconds 0..3 from the second driver.
  function automatic logic [2:0] remainFromDetail(input logic [1:0] detail);
    return REMAIN_MAX - {1'b0, detail};
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational digit-to-segment map for the countdown display; digits above
// the countdown range blank the display.
module seg7_decoder
  import countdown_pkg::*;
(
  input  logic [2:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (digit_i)
      3'd0:    seg_o = SEG_0;
      3'd1:    seg_o = SEG_1;
      3'd2:    seg_o = SEG_2;
      3'd3:    seg_o = SEG_3;
      3'd4:    seg_o = SEG_4;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Four-second countdown sequencer driving an external second driver and a
// seven-segment display. Define COUNTDOWN_BUZZER_EN to enable the buzzer output.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       countFinish,
  input  logic [1:0] countDetail,
  input  logic       flash,
  output logic       countEnable,
  output logic       busy,
  output logic       go,
  output logic [2:0] remaining,
  output logic [6:0] seg,
  output logic       dot,
  output logic       buzzer
);

  localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] holdCnt_q, holdCnt_d;
  logic        go_q, go_d;
  logic [2:0]  remaining_q, remaining_d;
  logic [6:0]  seg_q, seg_d;
  logic        holdExpired;

  assign holdExpired = (holdCnt_q == HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort has priority over every other request once a countdown is under way.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = ARM;
      end
      ARM: begin
        if (abort) state_d = IDLE;
        else       state_d = COUNT;
      end
      COUNT: begin
        if (abort)            state_d = IDLE;
        else if (countFinish) state_d = DONE;
      end
      DONE: begin
        if (abort)            state_d = IDLE;
        else if (start)       state_d = ARM;
        else if (holdExpired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    countEnable = (state_q == COUNT);
    busy        = (state_q != IDLE);
    go          = go_q;
    remaining   = remaining_q;
    seg         = seg_q;
    dot         = (state_q == COUNT) ? ~flash : 1'b1;
`ifdef COUNTDOWN_BUZZER_EN
    buzzer      = 1'b0;
    if (state_q == COUNT && remaining_q == 3'd1) buzzer = flash;
    else if (state_q == DONE)                   buzzer = 1'b1;
`else
    buzzer      = 1'b0;
`endif
  end

  // The hold counter sits at zero outside DONE, so it starts fresh on every entry.
  always_comb begin
    holdCnt_d = (state_q == DONE) ? holdCnt_q + 32'd1 : 32'd0;
    go_d      = (state_q == COUNT) && (state_d == DONE);
    case (state_q)
      COUNT:   remaining_d = remainFromDetail(countDetail);
      DONE:    remaining_d = 3'd0;
      default: remaining_d = REMAIN_MAX;
    endcase
  end

  seg7_decoder u_seg7 (
    .digit_i (remaining_d),
    .seg_o   (seg_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdCnt_q   <= 32'd0;
      go_q        <= 1'b0;
      remaining_q <= REMAIN_MAX;
      seg_q       <= SEG_4;
    end else begin
      holdCnt_q   <= holdCnt_d;
      go_q        <= go_d;
      remaining_q <= remaining_d;
      seg_q       <= seg_d;
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with a behavioural second driver that
// ticks every 4 clocks; buzzer expectations follow COUNTDOWN_BUZZER_EN.
module tb_countdown_sequencer;

  localparam int unsigned HOLD = 16;

`ifdef COUNTDOWN_BUZZER_EN
  localparam logic BUZ_ON = 1'b1;
`else
  localparam logic BUZ_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       countFinish;
  logic [1:0] countDetail;
  logic       flash;
  logic       countEnable;
  logic       busy;
  logic       go;
  logic [2:0] remaining;
  logic [6:0] seg;
  logic       dot;
  logic       buzzer;

  int testCount = 0;
  int failCount = 0;
  int goCount   = 0;
  int goBase;

  logic [1:0] tick;

  countdown_sequencer #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .countFinish (countFinish),
    .countDetail (countDetail),
    .flash       (flash),
    .countEnable (countEnable),
    .busy        (busy),
    .go          (go),
    .remaining   (remaining),
    .seg         (seg),
    .dot         (dot),
    .buzzer      (buzzer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Second driver: one second is 4 clocks, flash is high for the back half.
  initial begin
    tick        = 2'd0;
    countDetail = 2'd0;
    countFinish = 1'b0;
    flash       = 1'b0;
  end

  always @(negedge clk) begin
    if (!countEnable) begin
      tick        = 2'd0;
      countDetail = 2'd0;
      countFinish = 1'b0;
    end else if (tick == 2'd3) begin
      tick = 2'd0;
      if (countDetail == 2'd3) countFinish = 1'b1;
      else                     countDetail = countDetail + 2'd1;
    end else begin
      tick = tick + 2'd1;
    end
    flash = tick[1];
  end

  always @(negedge clk) begin
    if (go) goCount = goCount + 1;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    stepCycles(1);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_countEnable", 32'(countEnable), 32'd0);
    checkOutput("rst_busy",        32'(busy),        32'd0);
    checkOutput("rst_go",          32'(go),          32'd0);
    checkOutput("rst_remaining",   32'(remaining),   32'd4);
    checkOutput("rst_seg",         32'(seg),         32'h19);
    checkOutput("rst_dot",         32'(dot),         32'd1);
    checkOutput("rst_buzzer",      32'(buzzer),      32'd0);
    rst = 1'b0;
    stepCycles(2);

    // Full countdown to DONE and back to IDLE after the hold time.
    goBase = goCount;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_arm_busy",   32'(busy),        32'd1);
    checkOutput("t1_arm_en",     32'(countEnable), 32'd0);
    checkOutput("t1_arm_rem",    32'(remaining),   32'd4);
    stepCycles(1);
    checkOutput("t1_cnt_en",     32'(countEnable), 32'd1);
    checkOutput("t1_cnt_rem4",   32'(remaining),   32'd4);
    stepCycles(2);
    checkOutput("t1_dot_on",     32'(dot),         32'd0);
    checkOutput("t1_buz_rem4",   32'(buzzer),      32'd0);
    stepCycles(2);
    checkOutput("t1_rem3",       32'(remaining),   32'd3);
    checkOutput("t1_seg3",       32'(seg),         32'h30);
    stepCycles(4);
    checkOutput("t1_rem2",       32'(remaining),   32'd2);
    checkOutput("t1_seg2",       32'(seg),         32'h24);
    stepCycles(4);
    checkOutput("t1_rem1",       32'(remaining),   32'd1);
    checkOutput("t1_seg1",       32'(seg),         32'h79);
    checkOutput("t1_buz_flash0", 32'(buzzer),      32'd0);
    checkOutput("t1_dot_off",    32'(dot),         32'd1);
    stepCycles(2);
    checkOutput("t1_buz_flash1", 32'(buzzer),      32'(BUZ_ON));
    checkOutput("t1_dot_on2",    32'(dot),         32'd0);
    stepCycles(1);
    checkOutput("t1_pre_go",     32'(go),          32'd0);
    checkOutput("t1_pre_en",     32'(countEnable), 32'd1);
    stepCycles(1);
    checkOutput("t1_go",         32'(go),          32'd1);
    checkOutput("t1_done_en",    32'(countEnable), 32'd0);
    checkOutput("t1_done_busy",  32'(busy),        32'd1);
    checkOutput("t1_done_buz",   32'(buzzer),      32'(BUZ_ON));
    stepCycles(1);
    checkOutput("t1_go_low",     32'(go),          32'd0);
    checkOutput("t1_rem0",       32'(remaining),   32'd0);
    checkOutput("t1_seg0",       32'(seg),         32'h40);
    checkOutput("t1_done_buz2",  32'(buzzer),      32'(BUZ_ON));
    checkOutput("t1_done_dot",   32'(dot),         32'd1);
    stepCycles(14);
    checkOutput("t1_hold_busy",  32'(busy),        32'd1);
    stepCycles(1);
    checkOutput("t1_idle_busy",  32'(busy),        32'd0);
    checkOutput("t1_idle_buz",   32'(buzzer),      32'd0);
    stepCycles(1);
    checkOutput("t1_idle_rem",   32'(remaining),   32'd4);
    checkOutput("t1_go_count",   32'(goCount - goBase), 32'd1);

    // Abort while countDetail is 2.
    goBase = goCount;
    applyStimulus(1'b1, 1'b0);
    stepCycles(9);
    checkOutput("t2_rem2",       32'(remaining),   32'd2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t2_busy",       32'(busy),        32'd0);
    checkOutput("t2_en",         32'(countEnable), 32'd0);
    stepCycles(1);
    checkOutput("t2_rem4",       32'(remaining),   32'd4);
    checkOutput("t2_seg4",       32'(seg),         32'h19);
    checkOutput("t2_no_go",      32'(goCount - goBase), 32'd0);

    // Start alone in COUNT is ignored; start with abort returns to IDLE.
    applyStimulus(1'b1, 1'b0);
    stepCycles(2);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t3_start_busy", 32'(busy),        32'd1);
    checkOutput("t3_start_en",   32'(countEnable), 32'd1);
    checkOutput("t3_start_rem",  32'(remaining),   32'd4);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t3_both_busy",  32'(busy),        32'd0);
    checkOutput("t3_both_en",    32'(countEnable), 32'd0);
    stepCycles(2);

    // Reset between clock edges in the middle of COUNT.
    applyStimulus(1'b1, 1'b0);
    stepCycles(6);
    checkOutput("t4_rem3",       32'(remaining),   32'd3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t4_rst_en",     32'(countEnable), 32'd0);
    checkOutput("t4_rst_seg",    32'(seg),         32'h19);
    checkOutput("t4_rst_rem",    32'(remaining),   32'd4);
    checkOutput("t4_rst_busy",   32'(busy),        32'd0);
    stepCycles(1);
    rst = 1'b0;
    stepCycles(2);

    // Restart from DONE: ARM then COUNT at 4, no second go pulse.
    goBase = goCount;
    applyStimulus(1'b1, 1'b0);
    stepCycles(17);
    checkOutput("t5_go",         32'(go),          32'd1);
    stepCycles(3);
    checkOutput("t5_done_busy",  32'(busy),        32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_arm_busy",   32'(busy),        32'd1);
    checkOutput("t5_arm_en",     32'(countEnable), 32'd0);
    checkOutput("t5_arm_go",     32'(go),          32'd0);
    stepCycles(1);
    checkOutput("t5_cnt_en",     32'(countEnable), 32'd1);
    checkOutput("t5_cnt_rem",    32'(remaining),   32'd4);
    stepCycles(1);
    checkOutput("t5_cnt_rem2",   32'(remaining),   32'd4);
    checkOutput("t5_go_count",   32'(goCount - goBase), 32'd1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t5_abort_busy", 32'(busy),        32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
